// File: rtl/sdc_block_write_ctrl.sv
// SD-card single-block write sequencer for DAT0 in 1-bit mode: drives the
// data frame, then reads back the card's CRC-status token and waits out busy.
module sdc_block_write_ctrl #(
  parameter int BLOCK_BYTES    = 512,
  parameter int PRE_CYCLES     = 2,
  parameter int STATUS_TIMEOUT = 64,
  parameter int BUSY_TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       byte_req,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       crc_clr,
  output logic       crc_en,
  output logic       crc_shift,
  input  logic       crc_bit,
  output logic       sdc_dat_out,
  output logic       sdc_dat_oe,
  input  logic       sdc_dat_in,
  output logic       busy,
  output logic       done,
  output logic [2:0] err_code
);

  localparam int          NBITS     = 8 * BLOCK_BYTES;
  localparam logic [12:0] LAST_BIT  = 13'(NBITS - 1);
  localparam logic [12:0] LAST_LOAD = 13'(NBITS - 9);
  localparam logic [12:0] PRE_LAST  = 13'(PRE_CYCLES - 1);
  localparam logic [15:0] ST_TMO    = 16'(STATUS_TIMEOUT);
  localparam logic [15:0] BSY_TMO   = 16'(BUSY_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_START, S_DATA, S_CRC, S_END, S_WAIT_ST, S_STATUS, S_BUSY, S_DONE
  } state_t;

  state_t      state;
  logic [7:0]  shift_q;
  logic [7:0]  hold_q;
  logic        hold_full;
  logic [12:0] bit_cnt;
  logic [15:0] tcnt;
  logic        underrun;
  logic [2:0]  st_bits;
  logic        dat_q;
  logic        accept;

  function automatic logic [2:0] status_err(input logic [2:0] s);
    case (s)
      3'b010:  return 3'd0;
      3'b101:  return 3'd1;
      3'b110:  return 3'd2;
      default: return 3'd6;
    endcase
  endfunction

  assign accept = byte_req & byte_valid;
  // CRC bits come straight from the CRC unit so they line up with crc_shift.
  assign sdc_dat_out = (state == S_CRC) ? crc_bit : dat_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_full  <= 1'b0;
      bit_cnt    <= '0;
      tcnt       <= '0;
      underrun   <= 1'b0;
      st_bits    <= '0;
      dat_q      <= 1'b1;
      sdc_dat_oe <= 1'b0;
      byte_req   <= 1'b0;
      crc_clr    <= 1'b0;
      crc_en     <= 1'b0;
      crc_shift  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_code   <= '0;
    end else begin
      crc_clr <= 1'b0;
      done    <= 1'b0;
      if (accept) begin
        hold_q    <= byte_data;
        hold_full <= 1'b1;
        byte_req  <= 1'b0;
      end
      case (state)
        S_IDLE: if (start) begin
          state      <= S_PRE;
          busy       <= 1'b1;
          crc_clr    <= 1'b1;
          byte_req   <= 1'b1;
          hold_full  <= 1'b0;
          sdc_dat_oe <= 1'b1;
          dat_q      <= 1'b1;
          bit_cnt    <= '0;
          tcnt       <= '0;
          underrun   <= 1'b0;
          err_code   <= '0;
        end
        S_PRE: begin
          if (bit_cnt == PRE_LAST) begin
            state <= S_START;
            dat_q <= 1'b0;
            tcnt  <= '0;
          end else begin
            bit_cnt <= bit_cnt + 13'd1;
          end
        end
        S_START: begin
          if (!hold_full) begin
            state    <= S_END;
            dat_q    <= 1'b1;
            underrun <= 1'b1;
            err_code <= 3'd3;
            byte_req <= 1'b0;
          end else begin
            state     <= S_DATA;
            shift_q   <= hold_q;
            dat_q     <= hold_q[7];
            crc_en    <= 1'b1;
            hold_full <= accept;
            byte_req  <= !accept && (BLOCK_BYTES > 1);
            bit_cnt   <= '0;
          end
        end
        S_DATA: begin
          bit_cnt <= bit_cnt + 13'd1;
          if (bit_cnt == LAST_BIT) begin
            state     <= S_CRC;
            crc_en    <= 1'b0;
            crc_shift <= 1'b1;
            bit_cnt   <= '0;
          end else if (bit_cnt[2:0] == 3'd7) begin
            // Byte boundary: the next byte must already sit in the holding register.
            if (!hold_full) begin
              state    <= S_END;
              crc_en   <= 1'b0;
              dat_q    <= 1'b1;
              underrun <= 1'b1;
              err_code <= 3'd3;
              byte_req <= 1'b0;
            end else begin
              shift_q   <= hold_q;
              dat_q     <= hold_q[7];
              hold_full <= accept;
              byte_req  <= !accept && (bit_cnt != LAST_LOAD);
            end
          end else begin
            shift_q <= {shift_q[6:0], 1'b0};
            dat_q   <= shift_q[6];
          end
        end
        S_CRC: begin
          bit_cnt <= bit_cnt + 13'd1;
          if (bit_cnt == 13'd15) begin
            state     <= S_END;
            crc_shift <= 1'b0;
            dat_q     <= 1'b1;
          end
        end
        S_END: begin
          sdc_dat_oe <= 1'b0;
          tcnt       <= '0;
          if (underrun) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_WAIT_ST;
          end
        end
        S_WAIT_ST: begin
          if (!sdc_dat_in) begin
            state   <= S_STATUS;
            bit_cnt <= '0;
            tcnt    <= '0;
          end else if (tcnt == ST_TMO) begin
            state    <= S_DONE;
            done     <= 1'b1;
            err_code <= 3'd4;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_STATUS: begin
          bit_cnt <= bit_cnt + 13'd1;
          if (bit_cnt < 13'd3) st_bits <= {st_bits[1:0], sdc_dat_in};
          if (bit_cnt == 13'd3) begin
            state    <= S_BUSY;
            tcnt     <= '0;
            err_code <= status_err(st_bits);
          end
        end
        S_BUSY: begin
          if (sdc_dat_in) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (tcnt == BSY_TMO) begin
            state    <= S_DONE;
            done     <= 1'b1;
            err_code <= 3'd5;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdc_block_write_ctrl.md
Name: sdc_block_write_ctrl

Overview:
- Sequencer for one SD-card single-block write on DAT0, 1-bit bus mode.
- Drives the frame onto DAT0: start bit, BLOCK_BYTES data bytes MSB-first, 16 CRC bits from the external CRC16 unit, end bit.
- Then releases DAT0, decodes the card's CRC-status token and waits out card busy.
- Sits between the sector buffer (byte source), the CRC16 unit and the DAT0 pad driver; one pulse on start writes one block.

Parameters:
- BLOCK_BYTES, 512, data bytes per block; sets data-bit count = 8*BLOCK_BYTES.
- PRE_CYCLES, 2, cycles of DAT0=1 (oe=1) driven before the start bit.
- STATUS_TIMEOUT, 64, max cycles after end bit to see the status start bit.
- BUSY_TIMEOUT, 65535, max cycles DAT0 may stay low in busy.

Ports:
- clk  in  1  controller/SD clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to write a block; ignored unless idle.
- byte_req  out  1  request next byte; held high until byte_valid.
- byte_valid  in  1  byte_data valid; accepted only while byte_req=1.
- byte_data  in  8  next data byte.
- crc_clr  out  1  one-cycle clear of CRC16 unit.
- crc_en  out  1  CRC unit absorbs sdc_dat_out this cycle.
- crc_shift  out  1  CRC unit presents next CRC bit on crc_bit.
- crc_bit  in  1  CRC bit, MSB first, valid when crc_shift=1.
- sdc_dat_out  out  1  DAT0 output value.
- sdc_dat_oe  out  1  DAT0 output enable.
- sdc_dat_in  in  1  DAT0 input (card status/busy).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at end of transaction.
- err_code  out  3  result, valid with done and held until next start.

Behaviour:
- Reset (async, reset_n=0) values:
  - State IDLE; byte_req=0, crc_clr=0, crc_en=0, crc_shift=0.
  - sdc_dat_out=1, sdc_dat_oe=0, busy=0, done=0, err_code=0.
  - Hold and shift registers empty; counters 0.
- Reset mid-transaction aborts at once; oe drops asynchronously.
- Datapath registers:
  - 8-bit shift register plus 1-byte holding register with hold_full flag.
  - 13-bit bit counter; 16-bit timeout counter.
- IDLE -> PRE on start: assert crc_clr for 1 cycle; raise byte_req to prefetch into hold.
- PRE: oe=1, dat_out=1 for PRE_CYCLES cycles -> START.
- START, 1 cycle: dat_out=0.
  - hold_full=0 here -> END_BIT with err_code=3 (underrun).
  - Else load shift reg from hold, clear hold_full, re-raise byte_req -> DATA.
- DATA:
  - dat_out = shift[7]; crc_en=1.
  - Shift left each cycle; bit counter increments.
  - On bit 7 of a byte that is not the last: reload shift from hold, clear hold_full, raise byte_req.
  - If hold is empty at that point -> END_BIT, err_code=3.
  - byte_req is not raised after the last byte is loaded.
  - After bit 8*BLOCK_BYTES-1 -> CRC.
- Byte handshake:
  - byte_valid with byte_req=1 latches byte_data into hold, sets hold_full and drops byte_req the next cycle.
  - If byte_valid and a reload coincide, the reload takes the old hold; the new byte lands in hold the same edge.
- CRC: 16 cycles, crc_shift=1, crc_en=0, dat_out=crc_bit -> END_BIT.
- END_BIT: 1 cycle, dat_out=1, oe=1.
  - Normal path -> WAIT_ST.
  - Underrun path -> DONE with err 3; no status is read.
- WAIT_ST: oe=0; wait for sdc_dat_in=0.
  - Timeout counter > STATUS_TIMEOUT -> DONE, err 4.
  - sdc_dat_in=0 -> STATUS.
- STATUS: sample 3 bits over 3 cycles, then 1 end-bit cycle (value ignored) -> BUSY.
  - 010 accepted, err 0.
  - 101 CRC rejected, err 1.
  - 110 write error, err 2.
  - Any other pattern, err 6.
- BUSY: wait while sdc_dat_in=0.
  - First cycle with sdc_dat_in=1 -> DONE.
  - Exceeding BUSY_TIMEOUT cycles -> DONE, err 5 (overrides status code).
  - Busy is always waited out, even on err 1, 2 or 6.
- DONE: done=1 for 1 cycle -> IDLE.
- start while busy=1 is ignored. Timeout counter clears on every state entry.
- Data frame length: 1 + 8*BLOCK_BYTES + 16 + 1 bits; 4114 driven cycles after PRE for 512.

Test Plan:
- Nominal 512-byte write of bytes 0x00..0xFF twice, byte_valid 1 cycle after byte_req, card returns 0_010_1 then busy 100 cycles:
  - Expect 2+4114 cycles of oe=1 and correct serial bits.
  - Expect CRC bits equal to the CRC16 model, done with err_code=0.
- Card returns status 0_101_1 then busy 10 cycles -> done, err_code=1; status 0_110_1 -> err_code=2.
- Buffer withholds byte_valid for byte 37 -> END_BIT immediately after the last bit of byte 36, done 1 cycle later with err_code=3, oe=0.
- Card never drives DAT0 low after end bit -> done after 65 cycles in WAIT_ST, err_code=4.
- Busy held low for 70000 cycles (BUSY_TIMEOUT=65535) -> done, err_code=5; separately, bad status 0_111_1 -> err_code=6.
- reset_n pulsed low during DATA bit 1000 -> all outputs return to reset values immediately; a following start produces a clean full frame; start pulses while busy=1 have no effect.
